// File: rtl/axis_pkg.sv
// Shared AXI4-Stream types for the FIFO codebase slice.
package axis_pkg;

  localparam int unsigned AXIS_DATA_WIDTH = 32;

  typedef struct packed {
    logic                           tvalid;
    logic [AXIS_DATA_WIDTH-1:0]     tdata;
    logic [AXIS_DATA_WIDTH/8-1:0]   tkeep;
    logic                           tlast;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module axis_fifo_mem #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             ACLK,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge ACLK) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_packet_fifo.sv
// AXI4-Stream FIFO with optional store-and-forward on TLAST and forced release when a
// full FIFO holds no complete packet.
module axis_packet_fifo
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = AXIS_DATA_WIDTH,
  parameter int unsigned FIFO_LEN      = 16,
  parameter int unsigned PACKET_MODE   = 0,
  parameter int unsigned AFULL_THRESH  = FIFO_LEN - 2,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  axis_mosi_t                   in_mosi_i,
  output axis_miso_t                   in_miso_o,
  output axis_mosi_t                   out_mosi_o,
  input  axis_miso_t                   out_miso_i,
  input  logic                         flush_i,
  output logic [$clog2(FIFO_LEN+1)-1:0] level_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o,
  output logic                         oversize_o
);

  localparam int unsigned LW = $clog2(FIFO_LEN + 1);
  localparam int unsigned PW = $clog2(FIFO_LEN);
  localparam int unsigned KW = DATA_WIDTH / 8;
  localparam int unsigned EW = DATA_WIDTH + KW + 1;
  localparam logic [LW-1:0] FullLvl = LW'(FIFO_LEN);
  localparam logic [PW-1:0] LastPtr = PW'(FIFO_LEN - 1);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, pkt_cnt_q;
  logic          release_q;

  logic          in_ready, out_valid, wr_en, rd_en, wr_last, rd_last, force_release;
  logic [EW-1:0] wr_data, rd_data;

  assign in_ready  = (level_q != FullLvl) & ~flush_i;
  assign out_valid = (PACKET_MODE != 0) ?
                     ((level_q != '0) & ((pkt_cnt_q != '0) | release_q)) :
                     (level_q != '0);
  assign wr_en     = in_mosi_i.tvalid & in_ready;
  assign rd_en     = out_valid & out_miso_i.tready & ~flush_i;
  assign wr_last   = wr_en & in_mosi_i.tlast;
  assign rd_last   = rd_en & rd_data[0];

  // A full FIFO with no TLAST inside could never drain in store-and-forward mode.
  assign force_release = (PACKET_MODE != 0) & (level_q == FullLvl) & (pkt_cnt_q == '0) &
                         ~release_q;

  assign wr_data = {in_mosi_i.tdata[DATA_WIDTH-1:0], in_mosi_i.tkeep[KW-1:0], in_mosi_i.tlast};

  axis_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (FIFO_LEN),
    .AW    (PW)
  ) u_mem (
    .ACLK      (ACLK),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pkt_cnt_q <= '0;
      release_q <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pkt_cnt_q <= '0;
      release_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PW'(1);
      if (wr_en & ~rd_en) begin
        level_q <= level_q + LW'(1);
      end else if (~wr_en & rd_en) begin
        level_q <= level_q - LW'(1);
      end
      if (wr_last & ~rd_last) begin
        pkt_cnt_q <= pkt_cnt_q + LW'(1);
      end else if (~wr_last & rd_last) begin
        pkt_cnt_q <= pkt_cnt_q - LW'(1);
      end
      if (force_release) begin
        release_q <= 1'b1;
      end else if (rd_last) begin
        release_q <= 1'b0;
      end
    end
  end

  always_comb begin
    out_mosi_o                        = '0;
    out_mosi_o.tvalid                 = out_valid;
    out_mosi_o.tdata[DATA_WIDTH-1:0]  = rd_data[EW-1 -: DATA_WIDTH];
    out_mosi_o.tkeep[KW-1:0]          = rd_data[KW:1];
    out_mosi_o.tlast                  = rd_data[0];
  end

  assign in_miso_o.tready = in_ready;
  assign level_o          = level_q;
  assign almost_full_o    = 32'(level_q) >= AFULL_THRESH;
  assign almost_empty_o   = 32'(level_q) <= AEMPTY_THRESH;
  assign oversize_o       = force_release & ~flush_i;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Directed bench: a stream-mode and a packet-mode FIFO instance, both FIFO_LEN=4.
module tb_axis_packet_fifo;
  import axis_pkg::*;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axis_mosi_t s_in, s_out, p_in, p_out;
  axis_miso_t s_in_rdy, s_out_rdy, p_in_rdy, p_out_rdy;
  logic       s_flush, p_flush;
  logic [2:0] s_level, p_level;
  logic       s_af, s_ae, s_ov, p_af, p_ae, p_ov;

  int checks = 0;
  int errors = 0;

  axis_packet_fifo #(.DATA_WIDTH(32), .FIFO_LEN(4), .PACKET_MODE(0)) dut_s (
    .ACLK(ACLK), .ARESETn(ARESETn), .in_mosi_i(s_in), .in_miso_o(s_in_rdy),
    .out_mosi_o(s_out), .out_miso_i(s_out_rdy), .flush_i(s_flush), .level_o(s_level),
    .almost_full_o(s_af), .almost_empty_o(s_ae), .oversize_o(s_ov)
  );

  axis_packet_fifo #(.DATA_WIDTH(32), .FIFO_LEN(4), .PACKET_MODE(1)) dut_p (
    .ACLK(ACLK), .ARESETn(ARESETn), .in_mosi_i(p_in), .in_miso_o(p_in_rdy),
    .out_mosi_o(p_out), .out_miso_i(p_out_rdy), .flush_i(p_flush), .level_o(p_level),
    .almost_full_o(p_af), .almost_empty_o(p_ae), .oversize_o(p_ov)
  );

  task automatic step;
    @(posedge ACLK);
    #1;
  endtask

  task automatic s_drive(input logic v, input logic [31:0] d, input logic l);
    s_in.tvalid = v; s_in.tdata = d; s_in.tkeep = 4'hF; s_in.tlast = l;
  endtask

  task automatic p_drive(input logic v, input logic [31:0] d, input logic l);
    p_in.tvalid = v; p_in.tdata = d; p_in.tkeep = 4'hF; p_in.tlast = l;
  endtask

  task automatic test_reset;
    #2;
    checks += 6;
    if (s_in_rdy.tready !== 1'b1) begin errors++; $display("FAIL rst_tready got %b exp 1", s_in_rdy.tready); end
    if (s_out.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", s_out.tvalid); end
    if (s_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", s_level); end
    if (s_af !== 1'b0 || s_ae !== 1'b1) begin errors++; $display("FAIL rst_flags got af=%b ae=%b exp af=0 ae=1", s_af, s_ae); end
    if (p_out.tvalid !== 1'b0 || p_ov !== 1'b0) begin errors++; $display("FAIL rst_p_out got tv=%b ov=%b exp 0 0", p_out.tvalid, p_ov); end
    if (p_in_rdy.tready !== 1'b1 || p_level !== 3'd0) begin errors++; $display("FAIL rst_p_in got rdy=%b lvl=%0d exp 1 0", p_in_rdy.tready, p_level); end
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
  endtask

  task automatic test_stream_fill;
    s_out_rdy.tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_drive(1'b1, 32'hA0 + i, 1'b0);
      #1;
      checks++;
      if (s_in_rdy.tready !== 1'b1 || s_level !== 3'(i)) begin
        errors++; $display("FAIL fill_%0d got rdy=%b lvl=%0d exp rdy=1 lvl=%0d", i, s_in_rdy.tready, s_level, i);
      end
      step();
    end
    s_drive(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      s_out_rdy.tready = 1'b1;
      #1;
      if (i == 0) begin
        checks++;
        if (s_in_rdy.tready !== 1'b0 || s_af !== 1'b1) begin
          errors++; $display("FAIL full_flags got rdy=%b af=%b exp rdy=0 af=1", s_in_rdy.tready, s_af);
        end
      end
      checks += 3;
      if (s_out.tvalid !== 1'b1 || s_out.tdata !== 32'hA0 + i) begin
        errors++; $display("FAIL drain_data_%0d got tv=%b d=%0h exp tv=1 d=%0h", i, s_out.tvalid, s_out.tdata, 32'hA0 + i);
      end
      if (s_level !== 3'(4 - i)) begin errors++; $display("FAIL drain_level_%0d got %0d exp %0d", i, s_level, 4 - i); end
      if (s_ae !== ((4 - i) <= 1) || s_af !== ((4 - i) >= 2)) begin
        errors++; $display("FAIL drain_flags_%0d got ae=%b af=%b exp ae=%b af=%b", i, s_ae, s_af, (4 - i) <= 1, (4 - i) >= 2);
      end
      step();
    end
    #1;
    checks++;
    if (s_out.tvalid !== 1'b0 || s_level !== 3'd0) begin
      errors++; $display("FAIL drained got tv=%b lvl=%0d exp 0 0", s_out.tvalid, s_level);
    end
    step();
  endtask

  task automatic test_back_to_back;
    s_out_rdy.tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_drive(1'b1, 32'hB0 + i, 1'b0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      s_drive(1'b1, 32'hB2 + i, 1'b0);
      s_out_rdy.tready = 1'b1;
      #1;
      checks++;
      if (s_level !== 3'd2 || s_out.tvalid !== 1'b1 || s_out.tdata !== 32'hB0 + i) begin
        errors++; $display("FAIL b2b_%0d got lvl=%0d tv=%b d=%0h exp lvl=2 tv=1 d=%0h", i, s_level, s_out.tvalid, s_out.tdata, 32'hB0 + i);
      end
      step();
    end
    s_drive(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (s_out.tdata !== 32'hB5 + i || s_level !== 3'(2 - i)) begin
        errors++; $display("FAIL b2b_tail_%0d got d=%0h lvl=%0d exp d=%0h lvl=%0d", i, s_out.tdata, s_level, 32'hB5 + i, 2 - i);
      end
      step();
    end
    s_out_rdy.tready = 1'b0;
  endtask

  task automatic test_packet;
    p_out_rdy.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p_drive(1'b1, 32'hC0 + i, i == 2);
      #1;
      checks++;
      if (p_out.tvalid !== 1'b0) begin errors++; $display("FAIL pkt_hold_%0d got tv=%b exp 0", i, p_out.tvalid); end
      step();
    end
    p_drive(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (p_out.tvalid !== 1'b1 || p_out.tdata !== 32'hC0 + i || p_out.tlast !== (i == 2)) begin
        errors++; $display("FAIL pkt_out_%0d got tv=%b d=%0h last=%b exp tv=1 d=%0h last=%b", i, p_out.tvalid, p_out.tdata, p_out.tlast, 32'hC0 + i, i == 2);
      end
      step();
    end
    #1;
    checks++;
    if (p_out.tvalid !== 1'b0 || p_level !== 3'd0) begin
      errors++; $display("FAIL pkt_end got tv=%b lvl=%0d exp 0 0", p_out.tvalid, p_level);
    end
    step();
  endtask

  task automatic test_oversize;
    logic        iv   [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0};
    logic [31:0] idat [14] = '{'hD0, 'hD1, 'hD2, 'hD3, 'hD4, 'hD4, 'hD4, 'hD5, 0, 0, 0, 0, 'hE0, 0};
    logic        ilst [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    logic        ordy [14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    logic        etv  [14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [31:0] edat [14] = '{0, 0, 0, 0, 0, 'hD0, 'hD1, 'hD2, 'hD3, 'hD4, 'hD5, 0, 0, 0};
    logic        elst [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic        eov  [14] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [2:0]  elvl [14] = '{0, 1, 2, 3, 4, 4, 3, 3, 3, 2, 1, 0, 0, 1};
    for (int c = 0; c < 14; c++) begin
      p_drive(iv[c], idat[c], ilst[c]);
      p_out_rdy.tready = ordy[c];
      #1;
      checks += 3;
      if (p_ov !== eov[c]) begin errors++; $display("FAIL ovs_pulse_c%0d got %b exp %b", c, p_ov, eov[c]); end
      if (p_level !== elvl[c] || p_in_rdy.tready !== (elvl[c] != 3'd4)) begin
        errors++; $display("FAIL ovs_level_c%0d got lvl=%0d rdy=%b exp lvl=%0d rdy=%b", c, p_level, p_in_rdy.tready, elvl[c], elvl[c] != 3'd4);
      end
      if (p_out.tvalid !== etv[c] || (etv[c] && (p_out.tdata !== edat[c] || p_out.tlast !== elst[c]))) begin
        errors++; $display("FAIL ovs_out_c%0d got tv=%b d=%0h last=%b exp tv=%b d=%0h last=%b", c, p_out.tvalid, p_out.tdata, p_out.tlast, etv[c], edat[c], elst[c]);
      end
      step();
    end
  endtask

  task automatic test_flush;
    // Packet instance holds E0 without TLAST; grow to 3 beats mid-packet.
    p_out_rdy.tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      p_drive(1'b1, 32'hE1 + i, 1'b0);
      step();
    end
    p_drive(1'b1, 32'hE3, 1'b0);
    p_flush = 1'b1;
    #1;
    checks++;
    if (p_level !== 3'd3 || p_in_rdy.tready !== 1'b0 || p_out.tvalid !== 1'b0) begin
      errors++; $display("FAIL pflush_cycle got lvl=%0d rdy=%b tv=%b exp 3 0 0", p_level, p_in_rdy.tready, p_out.tvalid);
    end
    step();
    p_flush = 1'b0;
    p_drive(1'b0, 32'h0, 1'b0);
    #1;
    checks++;
    if (p_level !== 3'd0 || p_out.tvalid !== 1'b0) begin
      errors++; $display("FAIL pflush_after got lvl=%0d tv=%b exp 0 0", p_level, p_out.tvalid);
    end
    step();
    // Stream instance: a read would otherwise happen in the flush cycle.
    s_out_rdy.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_drive(1'b1, 32'hF0 + i, 1'b0);
      step();
    end
    s_drive(1'b1, 32'hF3, 1'b0);
    s_out_rdy.tready = 1'b1;
    s_flush = 1'b1;
    #1;
    checks++;
    if (s_level !== 3'd3 || s_in_rdy.tready !== 1'b0) begin
      errors++; $display("FAIL sflush_cycle got lvl=%0d rdy=%b exp 3 0", s_level, s_in_rdy.tready);
    end
    step();
    s_flush = 1'b0;
    s_drive(1'b1, 32'h60, 1'b0);
    s_out_rdy.tready = 1'b0;
    #1;
    checks++;
    if (s_level !== 3'd0 || s_out.tvalid !== 1'b0) begin
      errors++; $display("FAIL sflush_after got lvl=%0d tv=%b exp 0 0", s_level, s_out.tvalid);
    end
    step();
    s_drive(1'b0, 32'h0, 1'b0);
    #1;
    checks++;
    if (s_level !== 3'd1 || s_out.tvalid !== 1'b1 || s_out.tdata !== 32'h60) begin
      errors++; $display("FAIL sflush_next got lvl=%0d tv=%b d=%0h exp 1 1 60", s_level, s_out.tvalid, s_out.tdata);
    end
    step();
  endtask

  task automatic test_reset_mid;
    s_drive(1'b1, 32'h70, 1'b0);
    step();
    s_drive(1'b0, 32'h0, 1'b0);
    #1;
    checks++;
    if (s_level !== 3'd2) begin errors++; $display("FAIL pre_rst_level got %0d exp 2", s_level); end
    ARESETn = 1'b0;
    #1;
    checks++;
    if (s_level !== 3'd0 || s_out.tvalid !== 1'b0 || s_in_rdy.tready !== 1'b1 ||
        s_ae !== 1'b1 || s_af !== 1'b0 || s_ov !== 1'b0) begin
      errors++; $display("FAIL mid_rst got lvl=%0d tv=%b rdy=%b ae=%b af=%b ov=%b exp 0 0 1 1 0 0", s_level, s_out.tvalid, s_in_rdy.tready, s_ae, s_af, s_ov);
    end
    step();
    ARESETn = 1'b1;
    s_drive(1'b1, 32'h80, 1'b0);
    #1;
    checks++;
    if (s_out.tvalid !== 1'b0 || s_level !== 3'd0) begin
      errors++; $display("FAIL post_rst_idle got tv=%b lvl=%0d exp 0 0", s_out.tvalid, s_level);
    end
    step();
    s_drive(1'b0, 32'h0, 1'b0);
    #1;
    checks++;
    if (s_out.tvalid !== 1'b1 || s_out.tdata !== 32'h80 || s_level !== 3'd1) begin
      errors++; $display("FAIL post_rst_write got tv=%b d=%0h lvl=%0d exp 1 80 1", s_out.tvalid, s_out.tdata, s_level);
    end
  endtask

  initial begin
    s_in = '0; p_in = '0;
    s_out_rdy = '0; p_out_rdy = '0;
    s_flush = 1'b0; p_flush = 1'b0;
    test_reset();
    test_stream_fill();
    test_back_to_back();
    test_packet();
    test_oversize();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_packet_fifo.md
AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning TDATA width in bits; TKEEP width is DATA_WIDTH/8.
REQ-002 The block SHALL have parameter FIFO_LEN, default 16, meaning depth in beats; any value >= 2 is legal, not only powers of two.
REQ-003 The block SHALL have parameter PACKET_MODE, default 0, meaning 0 = stream (cut-through) and 1 = store-and-forward on TLAST.
REQ-004 The block SHALL have parameters AFULL_THRESH, default FIFO_LEN-2, and AEMPTY_THRESH, default 1, meaning the almost-flag levels.
REQ-005 The block SHALL have the following ports, clock and reset first:
- ACLK  in  1  clock.
- ARESETn  in  1  reset, asynchronous, active-low.
- in_mosi_i  in  axis_mosi_t  upstream TVALID/TDATA/TKEEP/TLAST.
- in_miso_o  out  axis_miso_t  upstream TREADY.
- out_mosi_o  out  axis_mosi_t  downstream TVALID/TDATA/TKEEP/TLAST.
- out_miso_i  in  axis_miso_t  downstream TREADY.
- flush_i  in  1  synchronous clear.
- level_o  out  $clog2(FIFO_LEN+1)  beats stored.
- almost_full_o  out  1  level_o >= AFULL_THRESH.
- almost_empty_o  out  1  level_o <= AEMPTY_THRESH.
- oversize_o  out  1  one-cycle pulse on forced release.

Function
REQ-006 Write handshake SHALL be in TVALID & in TREADY; read handshake SHALL be out TVALID & out TREADY.
REQ-007 in TREADY SHALL equal (level != FIFO_LEN) & !flush_i, with no write-through when full, even if a read occurs in the same cycle.
REQ-008 Each written beat SHALL store TDATA, TKEEP and TLAST together; output fields SHALL be driven combinationally from the read pointer entry.
REQ-009 Write-to-output latency SHALL be 1 cycle: a beat written at edge N is visible at out_mosi_o after edge N, with no empty bypass.
REQ-010 Read and write pointers SHALL wrap from FIFO_LEN-1 to 0.
REQ-011 level SHALL update as follows: +1 on write only, -1 on read only, unchanged on simultaneous read and write or on neither.
REQ-012 With PACKET_MODE=0, out TVALID SHALL equal level != 0.
REQ-013 With PACKET_MODE=1, a packet counter SHALL increment on a write of a TLAST beat, decrement on a read of a TLAST beat, and hold on both; out TVALID SHALL equal (level != 0) & (pkt_cnt != 0 | release).
REQ-014 Forced release (PACKET_MODE=1) SHALL work as follows:
- When level == FIFO_LEN and pkt_cnt == 0, the release flag SHALL set and oversize_o SHALL pulse for 1 cycle.
- release SHALL clear on the read handshake of a TLAST beat.
REQ-015 out TVALID SHALL not drop once asserted until the handshake, except on flush_i or reset.
REQ-016 flush_i SHALL have the following effect:
- It SHALL block writes in the same cycle.
- At the next edge it SHALL zero the pointers, level, pkt_cnt and release.
- It SHALL take priority over a simultaneous read.
REQ-017 level_o, almost_full_o and almost_empty_o SHALL be derived combinationally from the level register.

Reset
REQ-018 While ARESETn=0, the block SHALL hold pointers, level, pkt_cnt and release at 0, in TREADY at 1, out TVALID at 0, level_o at 0, almost_full_o at 0, almost_empty_o at 1 and oversize_o at 0.
REQ-019 Storage memory SHALL NOT be reset, and an assertion of ARESETn mid-packet SHALL discard all contents.

Structure
REQ-020 Package axis_pkg SHALL hold AXIS_DATA_WIDTH, axis_mosi_t (TVALID, TDATA, TKEEP, TLAST) and axis_miso_t (TREADY).
REQ-021 Storage SHALL be a sub-module axis_fifo_mem: simple dual-port, synchronous write, asynchronous read, no reset.
REQ-022 Pointer, level and packet logic SHALL stay in axis_packet_fifo.

Verification
REQ-023 The bench SHALL cover, at FIFO_LEN=4 and DATA_WIDTH=32 unless noted:
- Stream fill, out TREADY=0, write 0xA0..0xA3 -> in TREADY=0 after the 4th write, level_o=4, almost_full_o=1; drain -> 0xA0..0xA3 in order, almost_empty_o=1 at level 1.
- Level 2 with simultaneous read and write for 5 cycles, wrapping the pointers -> level_o stays 2, data order preserved.
- PACKET_MODE=1, 3-beat packet with TLAST on beat 3 -> out TVALID=0 until 1 cycle after the TLAST write, then 3 beats, TLAST on the 3rd.
- PACKET_MODE=1, 6-beat packet, no TLAST in the first 4 -> oversize_o pulses once at level 4, all 6 beats delivered in order, release cleared after TLAST read.
- flush_i at level 3 mid-packet with out TREADY=1 -> level_o=0 next cycle, out TVALID=0, no beat read in the flush cycle.
- ARESETn low for 1 cycle at level 2 -> outputs at reset values immediately; the next write appears after 1 cycle.
